// File: rtl/vending_pkg.sv
// Shared definitions for the vending coin interface: bus coin codes, price and
// the feeder state encoding.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  // Item price expressed in 5-unit steps.
  localparam int PRICE_UNITS = 4;

  typedef enum logic [2:0] {
    FD_IDLE,
    FD_COIN,
    FD_GAP,
    FD_WAIT,
    FD_DONE
  } feeder_state_t;

  // Value of a coin code in 5-unit steps; the unused code 11 counts as nothing.
  function automatic logic [1:0] coin_units(input logic [1:0] c);
    case (c)
      COIN_5:  coin_units = 2'd1;
      COIN_10: coin_units = 2'd2;
      default: coin_units = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/feeder_timeout_ctr.sv
// Loadable down-counter that flags its final cycle; bounds how long the feeder
// waits for a late dispense.
module feeder_timeout_ctr #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (en && cnt != '0)
      cnt <= cnt - W'(1);
  end

  // Loaded with TIMEOUT, so flagging at 1 gives exactly TIMEOUT enabled cycles.
  assign expired = (cnt == W'(1));

endmodule

// File: rtl/coin_feeder.sv
// Customer-side coin driver: inserts the fives then the tens of a purchase,
// one coin cycle then one idle cycle, and reports the outcome on a done pulse.
module coin_feeder
  import vending_pkg::*;
#(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_n5,
  input  logic [CNT_W-1:0] req_n10,
  output logic [1:0]       coin,
  input  logic             dispense,
  input  logic             chg5,
  output logic             done_valid,
  output logic             done_vended,
  output logic             done_chg5,
  output logic [CNT_W+1:0] done_credit,
  output logic [CNT_W:0]   done_unused
);

  localparam int CW = CNT_W + 2;
  localparam int UW = CNT_W + 1;

  feeder_state_t    state, nxt;
  logic [CNT_W-1:0] rem5, rem10, nrem5, nrem10;
  logic [CW-1:0]    credit, ncredit;
  logic             vended, nvended, chg5_q, nchg5;
  logic             tmr_load, tmr_en, tmr_exp;
  logic [1:0]       coin_sel;

  feeder_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    nxt      = state;
    nrem5    = rem5;
    nrem10   = rem10;
    ncredit  = credit;
    nvended  = vended;
    nchg5    = chg5_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    coin_sel = COIN_NONE;
    case (state)
      FD_IDLE: begin
        if (req_valid) begin
          nrem5   = req_n5;
          nrem10  = req_n10;
          ncredit = '0;
          nvended = 1'b0;
          nchg5   = 1'b0;
          nxt     = (req_n5 == '0 && req_n10 == '0) ? FD_DONE : FD_COIN;
        end
      end
      FD_COIN: begin
        coin_sel = (rem5 != '0) ? COIN_5 : COIN_10;
        if (rem5 != '0) nrem5  = rem5 - CNT_W'(1);
        else            nrem10 = rem10 - CNT_W'(1);
        ncredit = credit + CW'(coin_units(coin_sel));
        if (dispense) begin
          nvended = 1'b1;
          nchg5   = chg5;
          nxt     = FD_DONE;
        end else begin
          nxt = FD_GAP;
        end
      end
      FD_GAP: begin
        // A late Mealy dispense can still land in the idle cycle after a coin.
        if (dispense) begin
          nvended = 1'b1;
          nchg5   = chg5;
          nxt     = FD_DONE;
        end else if (rem5 != '0 || rem10 != '0) begin
          nxt = FD_COIN;
        end else begin
          tmr_load = 1'b1;
          nxt      = FD_WAIT;
        end
      end
      FD_WAIT: begin
        tmr_en = 1'b1;
        if (dispense) begin
          nvended = 1'b1;
          nchg5   = chg5;
          nxt     = FD_DONE;
        end else if (tmr_exp) begin
          nxt = FD_DONE;
        end
      end
      FD_DONE: nxt = FD_IDLE;
      default: nxt = FD_IDLE;
    endcase
  end

  // Bus-facing decode uses state and rem5 only, never dispense.
  assign coin      = coin_sel;
  assign req_ready = (state == FD_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FD_IDLE;
      rem5        <= '0;
      rem10       <= '0;
      credit      <= '0;
      vended      <= 1'b0;
      chg5_q      <= 1'b0;
      done_valid  <= 1'b0;
      done_vended <= 1'b0;
      done_chg5   <= 1'b0;
      done_credit <= '0;
      done_unused <= '0;
    end else begin
      state      <= nxt;
      rem5       <= nrem5;
      rem10      <= nrem10;
      credit     <= ncredit;
      vended     <= nvended;
      chg5_q     <= nchg5;
      done_valid <= (nxt == FD_DONE);
      // Result fields capture on entry to DONE and hold until the next one.
      if (nxt == FD_DONE) begin
        done_vended <= nvended;
        done_chg5   <= nchg5 & nvended;
        done_credit <= ncredit;
        done_unused <= UW'(nrem5) + UW'(nrem10);
      end
    end
  end

endmodule

// File: tb/tb_coin_feeder.sv
// Drives coin_feeder against a price-20 vending responder or random dispense
// injection, predicting each request's bus pattern and outcome arithmetically.
module tb_coin_feeder;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [CNT_W-1:0] req_n5 = '0, req_n10 = '0;
  logic [1:0]       coin;
  logic             dispense, chg5;
  logic             done_valid, done_vended, done_chg5;
  logic [CNT_W+1:0] done_credit;
  logic [CNT_W:0]   done_unused;

  logic mode = 1'b0;   // 0: vending responder, 1: injected dispense
  logic inj_d = 1'b0, inj_c = 1'b0, noise = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  coin_feeder #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_n5(req_n5), .req_n10(req_n10), .coin(coin), .dispense(dispense),
    .chg5(chg5), .done_valid(done_valid), .done_vended(done_vended),
    .done_chg5(done_chg5), .done_credit(done_credit), .done_unused(done_unused)
  );

  always #5 clk = ~clk;

  // Price-20 vending machine: vends the moment credit reaches 4 units.
  int   vcredit = 0;
  int   cval;
  logic vdisp, vchg;
  always_comb begin
    cval  = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
    vdisp = (cval != 0) && (vcredit + cval >= 4);
    vchg  = (vcredit + cval == 5);
  end
  always @(posedge clk) begin
    if (!rst) vcredit <= 0;
    else if (!mode && cval != 0) vcredit <= vdisp ? 0 : vcredit + cval;
  end

  assign dispense = mode ? inj_d : vdisp;
  assign chg5     = mode ? (inj_d ? inj_c : noise) : (vdisp ? vchg : noise);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One request from an IDLE negedge; d_inj is the injected dispense offset.
  task automatic run_req(input int n5, input int n10, input bit m,
                         input int d_inj, input bit ic);
    int coins[$];
    int total, k, c, done_off, done0, ecred, ecoin;
    bit vend, chg;
    coins = {};
    for (int i = 0; i < n5; i++)  coins.push_back(1);
    for (int i = 0; i < n10; i++) coins.push_back(2);
    total = n5 + n10;
    vend = 0; chg = 0; k = total;
    done0 = (total == 0) ? 1 : 2 * total + TIMEOUT + 1;
    done_off = done0;
    if (!m) begin
      c = vcredit;
      k = 0;
      foreach (coins[i]) begin
        c += coins[i];
        k++;
        if (c >= 4) begin vend = 1; chg = (c == 5); break; end
      end
      if (vend) done_off = 2 * k;
    end else if (d_inj < done0) begin
      vend = 1; chg = ic;
      k = ((d_inj + 1) / 2 < total) ? (d_inj + 1) / 2 : total;
      done_off = d_inj + 1;
    end
    ecred = 0;
    for (int i = 0; i < k; i++) ecred += coins[i];

    chk("ready_idle", req_ready, 1);
    mode = m; inj_d = 0; inj_c = ic;
    req_valid = 1; req_n5 = CNT_W'(n5); req_n10 = CNT_W'(n10);
    @(posedge clk);
    for (int j = 1; j <= done_off + 1; j++) begin
      @(negedge clk);
      ecoin = ((j % 2 == 1) && ((j + 1) / 2 <= k) && (j < done_off))
              ? coins[(j + 1) / 2 - 1] : 0;
      chk("coin", coin, (ecoin == 1) ? 1 : (ecoin == 2) ? 2 : 0);
      if (j <= done_off) begin
        chk("ready_busy", req_ready, 0);
        chk("done_valid", done_valid, (j == done_off) ? 1 : 0);
      end else begin
        chk("ready_after", req_ready, 1);
        chk("done_pulse_end", done_valid, 0);
      end
      if (j >= done_off) begin
        chk("vended", done_vended, vend);
        chk("chg5", done_chg5, vend & chg);
        chk("credit", done_credit, ecred);
        chk("unused", done_unused, total - k);
      end
      // Junk requests while busy must be ignored.
      req_valid = (j < done_off) ? 1'($urandom) : 1'b0;
      req_n5 = CNT_W'($urandom); req_n10 = CNT_W'($urandom);
      inj_d = m && (j == d_inj);
      noise = 1'($urandom);
    end
    inj_d = 0; req_valid = 0;
  endtask

  initial begin
    int n5, n10, d;
    bit m, ic;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_coin", coin, 0);
    chk("rst_dv", done_valid, 0);
    chk("rst_vended", done_vended, 0);
    chk("rst_credit", done_credit, 0);
    chk("rst_unused", done_unused, 0);
    rst = 1;
    @(negedge clk);

    run_req(0, 2, 0, 0, 0);
    run_req(1, 2, 0, 0, 0);
    run_req(0, 4, 0, 0, 0);
    run_req(1, 0, 0, 0, 0);
    run_req(0, 0, 0, 0, 0);
    run_req(0, 1, 1, 2, 1);   // dispense in GAP
    run_req(1, 0, 1, 5, 1);   // dispense in WAIT

    // Reset during the GAP of an n10=2 request abandons it silently.
    mode = 0; req_valid = 1; req_n5 = 0; req_n10 = 2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("rg_coin1", coin, 2);
    @(negedge clk);
    chk("rg_gap", coin, 0);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("rg_coin", coin, 0);
    chk("rg_ready", req_ready, 1);
    chk("rg_credit", done_credit, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rg_dv", done_valid, 0);
      @(negedge clk);
    end
    run_req(0, 2, 0, 0, 0);

    for (int r = 0; r < 60; r++) begin
      n5  = $urandom_range(0, 7);
      n10 = $urandom_range(0, 7);
      m   = 1'($urandom);
      ic  = 1'($urandom);
      d   = $urandom_range(1, 2 * (n5 + n10) + TIMEOUT + 3);
      run_req(n5, n10, m, d, ic);
      repeat ($urandom_range(0, 2)) begin
        noise = 1'($urandom);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_feeder.md
Name: coin_feeder

Overview:
- Initiator side of the vending coin interface: drives the 2-bit coin code into vending_mealy and consumes its dispense/chg5 replies.
- A purchase request names how many 5-unit and 10-unit coins are available. The block inserts them one at a time in the put5/put10 bus pattern: one coin cycle, then one idle cycle.
- It stops as soon as dispense is seen, then reports the outcome on a one-cycle done pulse.
- Used as the customer-side model/driver in system tests and the front-panel controller.

Parameters:
- TIMEOUT, 4, cycles to wait for dispense after the last coin's gap cycle before declaring no vend (>=1).
- CNT_W, 3, width of each per-denomination coin count.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- req_valid  in  1  purchase request valid
- req_ready  out  1  high only in IDLE
- req_n5  in  CNT_W  number of 5-unit coins available
- req_n10  in  CNT_W  number of 10-unit coins available
- coin  out  2  00 none, 01 five, 10 ten; 11 never driven
- dispense  in  1  from vending machine (Mealy, same cycle as coin)
- chg5  in  1  from vending machine, qualified by dispense
- done_valid  out  1  one-cycle completion pulse
- done_vended  out  1  item dispensed
- done_chg5  out  1  change of 5 returned
- done_credit  out  CNT_W+2  total inserted, in units of 5
- done_unused  out  CNT_W+1  coins not inserted (n5 plus n10 remaining)

Behaviour:
- Reset (rst==0 at an edge, any state):
  - state goes to IDLE; all counters clear.
  - coin=00, done_valid=0, done_vended=0, done_chg5=0, done_credit=0, done_unused=0, req_ready=1.
  - Reset mid-insertion abandons the request with no done pulse.
- States: IDLE, COIN, GAP, WAIT, DONE.
- IDLE:
  - req_ready=1, coin=00.
  - On req_valid at an edge: latch rem5=req_n5, rem10=req_n10, clear credit/vended/chg5.
  - Next state is COIN, or DONE if both counts are 0.
  - The first coin appears on the cycle right after acceptance.
- COIN:
  - coin=01 if rem5>0, else 10. All fives are inserted before tens.
  - At the edge: decrement the chosen rem; credit += 1 (five) or 2 (ten).
  - If dispense=1 this cycle: vended<=1, chg5_q<=chg5, go to DONE. Otherwise go to GAP.
- GAP:
  - coin=00.
  - Go to COIN if rem5+rem10>0; otherwise load the timer with TIMEOUT and go to WAIT.
  - dispense=1 in GAP is accepted as a vend (vended, chg5 captured), then go to DONE.
- WAIT:
  - coin=00; the timer decrements each cycle.
  - dispense=1 → vended, capture chg5, go to DONE.
  - Timer reaching 1 without dispense → DONE with vended=0.
  - WAIT therefore lasts exactly TIMEOUT cycles when no dispense arrives.
- DONE:
  - done_valid=1 for exactly one cycle.
  - done_vended, done_chg5 (=chg5_q & vended), done_credit and done_unused=rem5+rem10 are all valid this cycle.
  - Next state is IDLE. done_* outputs hold their values until the next DONE or reset; only done_valid pulses.
- Ignore rules:
  - dispense/chg5 in IDLE or DONE are ignored.
  - chg5 without dispense is ignored.
  - req_valid outside IDLE is ignored (req_ready=0).
- All outputs are registered except coin and req_ready, which decode from state and rem5 only, never combinationally from dispense.
- Arithmetic:
  - credit max 3*(2^CNT_W-1) fits CNT_W+2 bits.
  - unused max 2*(2^CNT_W-1) fits CNT_W+1 bits.
  - No wrap is possible.

Decomposition:
- Shared package vending_pkg holds:
  - coin codes COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10;
  - PRICE_UNITS=4 (price 20 in units of 5);
  - the feeder state enum.
- vending_mealy also adopts the coin codes from vending_pkg.
- One natural sub-module: feeder_timeout_ctr, a loadable down-counter with an expiry flag, used for WAIT.
- The rest stays flat.

Test Plan:
- Bench runs against vending_mealy (price 20), shared clk and rst.
- n5=0, n10=2 accepted at edge T:
  - coin=10 at T+1, 00 at T+2, 10 at T+3 with dispense;
  - done_valid at T+4: vended=1, chg5=0, credit=4, unused=0.
- n5=1, n10=2:
  - bus shows 01, 00, 10, 00, 10; dispense and chg5 on the last coin;
  - done: vended=1, chg5=1, credit=5, unused=0.
- n5=0, n10=4:
  - exactly two 10 pulses on the bus; dispense on the 2nd;
  - done: vended=1, credit=4, unused=2; no further coins.
- n5=1, n10=0, TIMEOUT=4:
  - one 01 pulse, 1 GAP cycle, 4 WAIT cycles;
  - done: vended=0, chg5=0, credit=1, unused=0.
- n5=0, n10=0:
  - done_valid on the cycle after acceptance; no coin pulses; vended=0, credit=0.
- rst=0 held for one edge during GAP of an n10=2 request:
  - next cycle coin=00, req_ready=1, done_valid never pulses;
  - a new request n10=2 then completes normally as in the first scenario.
